// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: op-code constants, the reserved code and a decode helper.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_AND      = 4'd0;
  localparam logic [OP_W-1:0] OP_OR       = 4'd1;
  localparam logic [OP_W-1:0] OP_XOR      = 4'd2;
  localparam logic [OP_W-1:0] OP_NOR      = 4'd3;
  localparam logic [OP_W-1:0] OP_RESERVED = 4'd4;
  localparam logic [OP_W-1:0] OP_ADD      = 4'd5;
  localparam logic [OP_W-1:0] OP_SUB      = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT      = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL      = 4'd8;
  localparam logic [OP_W-1:0] OP_SLL      = 4'd9;
  localparam logic [OP_W-1:0] OP_SRA      = 4'd10;

  // Code 4 and everything above SRA (11-15) have no operation assigned.
  function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
    return (op == OP_RESERVED) || (op > OP_SRA);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU with equal/overflow/zero flags and a reserved-op error.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [3:0]  op,
  output logic [31:0] z,
  output logic        equal,
  output logic        overflow,
  output logic        zero,
  output logic        err
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = x + y;
  assign diff = x - y;

  // Result and flags; reserved codes force every output except err to zero.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    z        = '0;
    overflow = 1'b0;
    err      = op_is_reserved(op);
    case (op)
      OP_AND: z = x & y;
      OP_OR:  z = x | y;
      OP_XOR: z = x ^ y;
      OP_NOR: z = ~(x | y);
      OP_ADD: begin
        z        = sum;
        overflow = (x[31] == y[31]) && (sum[31] != x[31]);
      end
      OP_SUB: begin
        z        = diff;
        overflow = (x[31] != y[31]) && (diff[31] != x[31]);
      end
      OP_SLT: z = {31'b0, ($signed(x) < $signed(y))};
      OP_SRL: z = x >> y[4:0];
      OP_SLL: z = x << y[4:0];
      OP_SRA: z = $unsigned($signed(x) >>> y[4:0]);
      default: z = '0;
    endcase
    equal = !err && (x == y);
    zero  = !err && (z == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU: IDLE grants and captures,
// EXEC registers the ALU result, RESP holds it until the consumer accepts.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [3:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_z,
  output logic        resp_equal,
  output logic        resp_overflow,
  output logic        resp_zero,
  output logic        resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [3:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_z_q, resp_z_d;
  logic        resp_equal_q, resp_equal_d;
  logic        resp_overflow_q, resp_overflow_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_err_q, resp_err_d;

  logic        any_valid;
  logic        grant_id;
  logic        take;
  logic [31:0] alu_z;
  logic        alu_equal, alu_overflow, alu_zero, alu_err;

  alu_arbiter_alu u_alu (
    .x        (x_q),
    .y        (y_q),
    .op       (op_q),
    .z        (alu_z),
    .equal    (alu_equal),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .err      (alu_err)
  );

  // Round-robin pick: on a tie the requester not granted last wins; a lone requester always wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    take      = (state_q == S_IDLE) && any_valid;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: capture and result registers are reset too, so a reset mid-operation leaves no stale response behind.
    if (rst) begin
      state_q         <= S_IDLE;
      last_q          <= ~RR_INIT;
      x_q             <= '0;
      y_q             <= '0;
      op_q            <= '0;
      id_q            <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_z_q        <= '0;
      resp_equal_q    <= 1'b0;
      resp_overflow_q <= 1'b0;
      resp_zero_q     <= 1'b0;
      resp_err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      state_q         <= state_d;
      last_q          <= last_d;
      x_q             <= x_d;
      y_q             <= y_d;
      op_q            <= op_d;
      id_q            <= id_d;
      resp_id_q       <= resp_id_d;
      resp_z_q        <= resp_z_d;
      resp_equal_q    <= resp_equal_d;
      resp_overflow_q <= resp_overflow_d;
      resp_zero_q     <= resp_zero_d;
      resp_err_q      <= resp_err_d;
    end
  end

  // Next state: capture on grant, register ALU result in EXEC, release on response accept.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    x_d             = x_q;
    y_d             = y_q;
    op_d            = op_q;
    id_d            = id_q;
    resp_id_d       = resp_id_q;
    resp_z_d        = resp_z_q;
    resp_equal_d    = resp_equal_q;
    resp_overflow_d = resp_overflow_q;
    resp_zero_d     = resp_zero_q;
    resp_err_d      = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_EXEC;
          last_d  = grant_id;
          id_d    = grant_id;
          x_d     = grant_id ? req1_x  : req0_x;
          y_d     = grant_id ? req1_y  : req0_y;
          op_d    = grant_id ? req1_op : req0_op;
        end
      end
      S_EXEC: begin
        state_d         = S_RESP;
        resp_id_d       = id_q;
        resp_z_d        = alu_z;
        resp_equal_d    = alu_equal;
        resp_overflow_d = alu_overflow;
        resp_zero_d     = alu_zero;
        resp_err_d      = alu_err;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE for the granted requester and never while reset is asserted.
  always_comb begin
    req0_ready    = !rst && take && !grant_id;
    req1_ready    = !rst && take && grant_id;
    resp_valid    = (state_q == S_RESP);
    resp_id       = resp_id_q;
    resp_z        = resp_z_q;
    resp_equal    = resp_equal_q;
    resp_overflow = resp_overflow_q;
    resp_zero     = resp_zero_q;
    resp_err      = resp_err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset-in-flight sequence,
// then random transactions checked against a transaction-level reference model.
module tb_alu_arbiter;

  typedef struct packed {
    logic        err;
    logic        eq;
    logic        ov;
    logic        zero;
    logic [31:0] z;
  } resp_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] x0;
    logic [31:0] y0;
    logic [3:0]  op0;
    logic [31:0] x1;
    logic [31:0] y1;
    logic [3:0]  op1;
    int          hold;
    logic        exp_id;
    resp_t       exp;
  } vec_t;

  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_z;
  logic        resp_equal, resp_overflow, resp_zero, resp_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic model_last;

  vec_t tbl[17];

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_x        (req0_x),
    .req0_y        (req0_y),
    .req0_op       (req0_op),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_x        (req1_x),
    .req1_y        (req1_y),
    .req1_op       (req1_op),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_z        (resp_z),
    .resp_equal    (resp_equal),
    .resp_overflow (resp_overflow),
    .resp_zero     (resp_zero),
    .resp_err      (resp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic resp_t dut_resp();
    return '{resp_err, resp_equal, resp_overflow, resp_zero, resp_z};
  endfunction

  // Reference ALU from the op table using wide signed arithmetic.
  function automatic resp_t alu_model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    resp_t  r;
    longint sx, sy, s;
    int     sh;
    r  = '0;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y % 32);
    if (op == 4'd4 || op > 4'd10) begin
      r.err = 1'b1;
      return r;
    end
    case (op)
      4'd0: r.z = x & y;
      4'd1: r.z = x | y;
      4'd2: r.z = x ^ y;
      4'd3: r.z = ~(x | y);
      4'd5: begin s = sx + sy; r.z = s[31:0]; r.ov = (s > S32_MAX) || (s < S32_MIN); end
      4'd6: begin s = sx - sy; r.z = s[31:0]; r.ov = (s > S32_MAX) || (s < S32_MIN); end
      4'd7: r.z = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: r.z = x >> sh;
      4'd9: r.z = x << sh;
      default: begin s = sx >>> sh; r.z = s[31:0]; end
    endcase
    r.eq   = (x == y);
    r.zero = (r.z == 32'd0);
    return r;
  endfunction

  function automatic vec_t mk(input logic v0, input logic v1,
                              input logic [31:0] x0, input logic [31:0] y0, input logic [3:0] op0,
                              input logic [31:0] x1, input logic [31:0] y1, input logic [3:0] op1,
                              input int hold, input logic exp_id, input resp_t exp);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.x0 = x0; v.y0 = y0; v.op0 = op0;
    v.x1 = x1; v.y1 = y1; v.op1 = op1; v.hold = hold; v.exp_id = exp_id; v.exp = exp;
    return v;
  endfunction

  // One full transaction: grant cycle, EXEC, RESP held for 'hold' cycles, then accept.
  task automatic run_txn(input string tag, input logic v0, input logic v1,
                         input logic [31:0] x0, input logic [31:0] y0, input logic [3:0] op0,
                         input logic [31:0] x1, input logic [31:0] y1, input logic [3:0] op1,
                         input int hold, input logic exp_id, input resp_t exp);
    @(negedge clk);
    req0_valid = v0; req0_x = x0; req0_y = y0; req0_op = op0;
    req1_valid = v1; req1_x = x1; req1_y = y1; req1_op = op1;
    resp_ready = 1'b0;
    #1;
    check($sformatf("%s idle_resp_valid", tag), {63'd0, resp_valid}, 64'd0);
    check($sformatf("%s grant", tag), {62'd0, req1_ready, req0_ready}, exp_id ? 64'd2 : 64'd1);
    @(negedge clk);
    #1;
    check($sformatf("%s exec_ready", tag), {62'd0, req1_ready, req0_ready}, 64'd0);
    check($sformatf("%s exec_resp_valid", tag), {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    #1;
    check($sformatf("%s resp_valid", tag), {63'd0, resp_valid}, 64'd1);
    check($sformatf("%s resp_id", tag), {63'd0, resp_id}, {63'd0, exp_id});
    check($sformatf("%s resp", tag), {28'd0, dut_resp()}, {28'd0, exp});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check($sformatf("%s hold%0d valid", tag, h), {63'd0, resp_valid}, 64'd1);
      check($sformatf("%s hold%0d resp", tag, h), {27'd0, resp_id, dut_resp()}, {27'd0, exp_id, exp});
      check($sformatf("%s hold%0d ready", tag, h), {62'd0, req1_ready, req0_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    #1;
    check($sformatf("%s accept_ready", tag), {62'd0, req1_ready, req0_ready}, 64'd0);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    // Directed vectors; history starts right after reset with requester 0 winning the first tie.
    tbl[0]  = mk(1, 1, 32'd9, 32'd9, 4'd6, 32'hF0, 32'h0F, 4'd1, 0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
    tbl[1]  = mk(1, 1, 32'd9, 32'd9, 4'd6, 32'hF0, 32'h0F, 4'd1, 0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFF});
    tbl[2]  = mk(1, 1, 32'd9, 32'd9, 4'd6, 32'hF0, 32'h0F, 4'd1, 1, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
    tbl[3]  = mk(1, 0, 32'd5, 32'd7, 4'd5, 32'd0, 32'd0, 4'd0, 0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 32'd12});
    tbl[4]  = mk(1, 0, 32'h7FFFFFFF, 32'd1, 4'd5, 32'd0, 32'd0, 4'd0, 4, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000});
    tbl[5]  = mk(0, 1, 32'd0, 32'd0, 4'd0, 32'd3, 32'd3, 4'hC, 0, 1'b1, '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    tbl[6]  = mk(0, 1, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd4, 2, 1'b1, '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    tbl[7]  = mk(1, 0, 32'h80000000, 32'd1, 4'd6, 32'd0, 32'd0, 4'd0, 0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF});
    tbl[8]  = mk(0, 1, 32'd0, 32'd0, 4'd0, 32'hFFFFFFFF, 32'd1, 4'd7, 0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1});
    tbl[9]  = mk(1, 0, 32'h80000000, 32'd4, 4'd10, 32'd0, 32'd0, 4'd0, 0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 32'hF8000000});
    tbl[10] = mk(0, 1, 32'd0, 32'd0, 4'd0, 32'h80000000, 32'd4, 4'd8, 0, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h08000000});
    tbl[11] = mk(1, 0, 32'd1, 32'd31, 4'd9, 32'd0, 32'd0, 4'd0, 0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000});
    tbl[12] = mk(0, 1, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd3, 0, 1'b1, '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF});
    tbl[13] = mk(1, 0, 32'hF0F0, 32'h0F0F, 4'd0, 32'd0, 32'd0, 4'd0, 0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    tbl[14] = mk(1, 1, 32'd5, 32'd5, 4'd2, 32'd1, 32'd1, 4'd5, 0, 1'b1, '{1'b0, 1'b1, 1'b0, 1'b0, 32'd2});
    tbl[15] = mk(1, 1, 32'd5, 32'd5, 4'd2, 32'd1, 32'd1, 4'd5, 0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
    tbl[16] = mk(0, 1, 32'd0, 32'd0, 4'd0, 32'd1, 32'd2, 4'hF, 0, 1'b1, '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0});

    // Reset with both requesters pending: nothing may be granted, all responses cleared.
    rst = 1'b1;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 32'd1; req0_y = 32'd2; req0_op = 4'd5;
    req1_valid = 1'b1; req1_x = 32'd3; req1_y = 32'd4; req1_op = 4'd5;
    #2;
    check("reset ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset resp", {27'd0, resp_id, dut_resp()}, 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    foreach (tbl[i])
      run_txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].x0, tbl[i].y0, tbl[i].op0,
              tbl[i].x1, tbl[i].y1, tbl[i].op1, tbl[i].hold, tbl[i].exp_id, tbl[i].exp);

    // Reset in EXEC: requester 0 is granted (so it is the last grant), then reset hits.
    @(negedge clk);
    req0_valid = 1'b1; req0_x = 32'd10; req0_y = 32'd20; req0_op = 4'd5;
    req1_valid = 1'b0;
    #1;
    check("rst_exec grant", {62'd0, req1_ready, req0_ready}, 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_exec ready_in_reset", {62'd0, req1_ready, req0_ready}, 64'd0);
    check("rst_exec resp_cleared", {27'd0, resp_id, dut_resp()}, 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_exec no_resp%0d", c), {63'd0, resp_valid}, 64'd0);
    end
    run_txn("rst_exec tie", 1, 1, 32'h55, 32'h0F, 4'd2, 32'h55, 32'h0F, 4'd0, 0, 1'b0,
            alu_model(32'h55, 32'h0F, 4'd2));
    model_last = 1'b0;

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        v0, v1, gid;
      logic [31:0] x0, y0, x1, y1;
      logic [3:0]  op0, op1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      x0 = $urandom;
      y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
      x1 = $urandom;
      y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      gid = (v0 && v1) ? !model_last : v1;
      model_last = gid;
      run_txn($sformatf("rand%0d", i), v0, v1, x0, y0, op0, x1, y1, op1,
              $urandom_range(0, 3), gid,
              gid ? alu_model(x1, y1, op1) : alu_model(x0, y0, op0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, meaning: requester holding priority after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_x, req0_y  input  32 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 ALU op code.
REQ-008 req1_valid, req1_ready, req1_x, req1_y, req1_op  same widths and meaning as the req0 ports, for requester 1.
REQ-009 resp_valid  output  1  response available.
REQ-010 resp_ready  input  1  response consumer accepts.
REQ-011 resp_id  output  1  requester that issued the operation.
REQ-012 resp_z  output  32  ALU result.
REQ-013 resp_equal, resp_overflow, resp_zero  output  1 each  ALU flags for the operation.
REQ-014 resp_err  output  1  op code was reserved.

Function
REQ-015 Block SHALL time-share one ALU instance between two requesters using valid/ready handshakes.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 In IDLE, if any reqN_valid is high, the block SHALL assert exactly one reqN_ready combinationally, capture that requester's x, y, op and id, and go to EXEC.
REQ-018 reqN_ready SHALL be low in EXEC and RESP and for the non-granted requester.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of priority.
REQ-020 The last-grant register SHALL update only on a completed request transfer.
REQ-021 In EXEC, the captured operands and op SHALL drive the ALU. Z and all flags SHALL be registered into the resp_* outputs. The state SHALL go to RESP.
REQ-022 In RESP, resp_valid SHALL be high and all resp_* outputs SHALL stay stable until resp_ready is high. On that edge the state SHALL return to IDLE.
REQ-023 Latency from request transfer edge to resp_valid high SHALL be 2 cycles.
REQ-024 Minimum spacing between grants SHALL be 3 cycles.
REQ-025 The response-accept edge SHALL NOT also accept a new request; IDLE always lasts at least 1 cycle.
REQ-026 Op codes 4 and 11-15 are reserved. For them, resp_err=1, resp_z=0, and resp_equal, resp_overflow and resp_zero=0. For valid codes, resp_err=0.
REQ-027 Op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOR, 5 ADD, 6 SUB, 7 SLT, 8 SRL, 9 SLL, 10 SRA.
REQ-028 resp_overflow SHALL be passed through from the ALU unmodified; it is meaningful for ADD/SUB only.
REQ-029 The block SHALL accept reqN_valid deasserting while not granted; no request is latched before its grant.

Reset
REQ-030 On rst high, the block SHALL asynchronously enter IDLE with resp_valid=0, resp_id=0, resp_z=0, all flags=0 and resp_err=0.
REQ-031 After reset, the last-grant register SHALL be ~RR_INIT, so requester RR_INIT wins the first tie.
REQ-032 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-033 With rst high, req0_ready and req1_ready SHALL be 0.

Structure
REQ-034 Op-code constants and the RESERVED value SHALL live in the shared alu_defines include; FSM state encodings SHALL be local localparams.
REQ-035 The block SHALL instantiate exactly one existing alu sub-module. Arbitration, capture registers and FSM SHALL be in alu_arbiter.

Verification
REQ-036 Scenario 1: req0 ADD x=5, y=7 alone -> req0_ready for 1 cycle; resp_valid 2 cycles later with resp_z=12, resp_id=0, zero=0, err=0.
REQ-037 Scenario 2: both valid continuously, req0 SUB 9-9, req1 OR 0xF0|0x0F -> grants alternate 0,1,0,… from reset (RR_INIT=0); responses are z=0 with zero=1, then z=0xFF.
REQ-038 Scenario 3: ADD x=0x7FFFFFFF, y=1 -> resp_z=0x80000000, resp_overflow=1.
REQ-039 Scenario 4: resp_ready held low 4 cycles during RESP -> resp_* stable throughout; both reqN_ready stay 0 until 1 cycle after acceptance.
REQ-040 Scenario 5: op=4'hC -> resp_err=1, resp_z=0, flags=0.
REQ-041 Scenario 6: rst pulsed mid-EXEC -> resp_valid never asserts for that op; the next request completes normally with the RR_INIT requester winning the first tie.
